draw_arbiter: RTL and testbench
===============================

DRAW_ARBITER -- requirements
Module: draw_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 20'd1023: maximum RUN cycles per grant.
REQ-002 Parameter LOGIC_CYCLES, default 20'd12: wait cycles after logic_go before the draw phase.
REQ-003 Clock: one clock, clk, rising edge; reset is asynchronous and active-low, resetn.
REQ-004 clk  in  1  system clock (CLOCK_50 domain).
REQ-005 resetn  in  1  asynchronous active-low reset.
REQ-006 frame_tick  in  1  one-cycle pulse from delay_counter that starts a frame.
REQ-007 req  in  3  requester wants service this frame; index 0 ball, 1 brick, 2 plat.
REQ-008 done  in  3  requester finished its sprite; sampled only while granted.
REQ-009 x_in, y_in  in  30 each  packed 10-bit pixel coordinates; requester i occupies bits [10i+9:10i].
REQ-010 colour_in  in  9  packed 3-bit colour; requester i occupies bits [3i+2:3i].
REQ-011 wen_in  in  3  per-requester pixel write strobe.
REQ-012 go  out  3  one-cycle start pulse to the granted requester.
REQ-013 grant  out  3  one-hot current owner; 0 when no owner.
REQ-014 x, y  out  10 each; colour  out  3; writeEn  out  1  pixel port to the VGA adapter.
REQ-015 erase  out  1  high during the erase phase.
REQ-016 logic_go  out  1  one-cycle game-logic update pulse.
REQ-017 busy  out  1  high whenever the state is not IDLE.
REQ-018 timeout_err, overrun_err  out  1 each  sticky error flags.

Function
REQ-019 States SHALL be IDLE, SCAN, GO, RUN, LOGIC, LOGIC_WAIT.
REQ-020 Frame start: on frame_tick in IDLE, the arbiter SHALL latch req into req_snap, clear the served mask, set phase=ERASE and go to SCAN.
REQ-021 SCAN: pending = req_snap & ~served; if pending is nonzero, the arbiter SHALL pick round-robin, search order ptr, ptr+1, ptr+2 mod 3, load grant and go to GO.
REQ-022 GO: go[g]=1 for exactly one cycle, then RUN; done SHALL be ignored in GO.
REQ-023 RUN: a cycle counter counts from 0; exit when done[g]=1 or count==TIMEOUT; on exit set served[g], set ptr=(g+1) mod 3, clear grant, return to SCAN.
REQ-024 Timeout exit SHALL set timeout_err; if done and timeout coincide, the exit is a done exit and timeout_err SHALL NOT be set.
REQ-025 SCAN, pending empty, phase ERASE: go to LOGIC; logic_go=1 for one cycle; then LOGIC_WAIT for LOGIC_CYCLES cycles; then phase=DRAW, clear served, return to SCAN using the same req_snap.
REQ-026 SCAN, pending empty, phase DRAW: go to IDLE.
REQ-027 An empty req_snap SHALL still produce the logic_go pulse, with zero grants in either phase.
REQ-028 Pixel mux, RUN only: x, y and writeEn SHALL come from the granted slice; colour=3'b000 when erase, else colour_in slice.
REQ-029 Outside RUN: writeEn=0, x=0, y=0, colour=0.
REQ-030 Pixel outputs SHALL be combinational from the grant; zero added latency.
REQ-031 frame_tick while not IDLE SHALL be ignored and SHALL set overrun_err.
REQ-032 req changes mid-frame SHALL have no effect until the next frame_tick.
REQ-033 Latency: frame_tick at cycle 0 -> SCAN at 1 -> go pulse at 2 -> RUN from 3.
REQ-034 erase SHALL be 1 only in non-IDLE states with phase ERASE.
REQ-035 Counters SHALL be 20 bits; each requester SHALL be granted at most once per phase.

Reset
REQ-036 resetn low SHALL asynchronously force state IDLE, phase ERASE, ptr=0, served=0, req_snap=0, counter=0, and every output 0, including both error flags.
REQ-037 Reset mid-RUN SHALL drop the grant and writeEn immediately, with no go or logic_go pulse on release.

Structure
REQ-038 Shared package draw_pkg SHALL hold the state encodings, requester indices BALL=0 / BRICK=1 / PLAT=2, BLACK=3'b000, and the coordinate width of 10.
REQ-039 One sub-module, rr_pick, SHALL map (pending[2:0], ptr) to a one-hot grant and a valid flag, combinationally.

Verification
REQ-040 req=3'b111, each done 5 cycles after go: erase grants ball, brick, plat; logic_go pulses once; draw grants in the same order; 6 go pulses total; then IDLE.
REQ-041 req=3'b010, brick never asserts done, TIMEOUT=20: grant held for 21 RUN cycles; timeout_err=1; the frame still completes.
REQ-042 Erase phase with colour_in=9'h1FF and wen_in=3'b111: colour=0 on every writeEn cycle; in the draw phase colour=3'b111.
REQ-043 Second frame_tick 4 cycles into a frame: overrun_err=1; grant order unchanged.
REQ-044 req=3'b000: logic_go pulses at cycle 2; busy falls after LOGIC_CYCLES+3 cycles; go never asserted.
REQ-045 resetn low during brick RUN: grant=0 and writeEn=0 at once; after release, nothing happens until the next frame_tick.

Source files
------------

// File: rtl/draw_pkg.sv
// Shared constants for the sprite draw arbiter: FSM encodings, requester
// indices, pixel field widths and the erase colour.
package draw_pkg;

  localparam int unsigned COORD_W  = 10;
  localparam int unsigned COLOUR_W = 3;

  localparam int unsigned BALL  = 0;
  localparam int unsigned BRICK = 1;
  localparam int unsigned PLAT  = 2;

  localparam logic [2:0] BLACK = 3'b000;

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_SCAN       = 3'd1;
  localparam logic [2:0] S_GO         = 3'd2;
  localparam logic [2:0] S_RUN        = 3'd3;
  localparam logic [2:0] S_LOGIC      = 3'd4;
  localparam logic [2:0] S_LOGIC_WAIT = 3'd5;

  localparam logic PH_ERASE = 1'b0;
  localparam logic PH_DRAW  = 1'b1;

endpackage

// File: rtl/rr_pick.sv
// Three-way round-robin picker: first pending requester at or after ptr,
// wrapping mod 3, returned one-hot.
module rr_pick (
  input  logic [2:0] pending,
  input  logic [1:0] ptr,
  output logic [2:0] pick,
  output logic       valid
);

  logic [2:0] rot;
  logic [2:0] sel;

  // Rotate so bit 0 is the requester at ptr, pick lowest, rotate back.
  always_comb begin
    case (ptr)
      2'd1:    rot = {pending[0], pending[2], pending[1]};
      2'd2:    rot = {pending[1], pending[0], pending[2]};
      default: rot = pending;
    endcase

    if (rot[0])      sel = 3'b001;
    else if (rot[1]) sel = 3'b010;
    else if (rot[2]) sel = 3'b100;
    else             sel = 3'b000;

    case (ptr)
      2'd1:    pick = {sel[1], sel[0], sel[2]};
      2'd2:    pick = {sel[0], sel[2], sel[1]};
      default: pick = sel;
    endcase
  end

  assign valid = |pending;

endmodule

// File: rtl/draw_arbiter.sv
// Frame sequencer for three sprite engines: erase pass, game-logic update,
// then draw pass, granting the VGA pixel port round-robin to each requester.
//
// state      | meaning
// IDLE       | waiting for frame_tick
// SCAN       | choose next pending requester, or advance phase
// GO         | one-cycle start pulse to the granted requester
// RUN        | requester owns the pixel port until done or timeout
// LOGIC      | one-cycle logic_go pulse after the erase pass
// LOGIC_WAIT | let game logic settle before the draw pass
module draw_arbiter
  import draw_pkg::*;
#(
  parameter logic [19:0] TIMEOUT      = 20'd1023,
  parameter logic [19:0] LOGIC_CYCLES = 20'd12
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  frame_tick,
  input  logic [2:0]            req,
  input  logic [2:0]            done,
  input  logic [3*COORD_W-1:0]  x_in,
  input  logic [3*COORD_W-1:0]  y_in,
  input  logic [3*COLOUR_W-1:0] colour_in,
  input  logic [2:0]            wen_in,
  output logic [2:0]            go,
  output logic [2:0]            grant,
  output logic [COORD_W-1:0]    x,
  output logic [COORD_W-1:0]    y,
  output logic [COLOUR_W-1:0]   colour,
  output logic                  writeEn,
  output logic                  erase,
  output logic                  logic_go,
  output logic                  busy,
  output logic                  timeout_err,
  output logic                  overrun_err
);

  localparam logic [19:0] LC_LAST = (LOGIC_CYCLES == 20'd0) ? 20'd0 : LOGIC_CYCLES - 20'd1;

  logic [2:0]  state;
  logic        phase;
  logic [1:0]  ptr;
  logic [2:0]  served;
  logic [2:0]  req_snap;
  logic [19:0] count;

  logic [2:0]  pending;
  logic [2:0]  pick;
  logic        pick_valid;
  logic [1:0]  ptr_next;
  logic        done_hit;
  logic        tmo_hit;

  assign pending  = req_snap & ~served;
  assign done_hit = |(done & grant);
  assign tmo_hit  = (count == TIMEOUT);

  rr_pick u_pick (
    .pending (pending),
    .ptr     (ptr),
    .pick    (pick),
    .valid   (pick_valid)
  );

  always_comb begin
    ptr_next = 2'(BALL);
    if (grant[BALL])       ptr_next = 2'(BRICK);
    else if (grant[BRICK]) ptr_next = 2'(PLAT);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= S_IDLE;
      phase       <= PH_ERASE;
      ptr         <= 2'd0;
      served      <= 3'b000;
      req_snap    <= 3'b000;
      count       <= 20'd0;
      grant       <= 3'b000;
      timeout_err <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      if (frame_tick && state != S_IDLE) overrun_err <= 1'b1;

      case (state)
        S_IDLE: begin
          if (frame_tick) begin
            req_snap <= req;
            served   <= 3'b000;
            phase    <= PH_ERASE;
            state    <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (pick_valid) begin
            grant <= pick;
            state <= S_GO;
          end else if (phase == PH_ERASE) begin
            state <= S_LOGIC;
          end else begin
            state <= S_IDLE;
          end
        end
        S_GO: begin
          count <= 20'd0;
          state <= S_RUN;
        end
        S_RUN: begin
          if (done_hit || tmo_hit) begin
            served <= served | grant;
            ptr    <= ptr_next;
            grant  <= 3'b000;
            state  <= S_SCAN;
            // done wins a tie with the timeout
            if (!done_hit) timeout_err <= 1'b1;
          end else begin
            count <= count + 20'd1;
          end
        end
        S_LOGIC: begin
          count <= 20'd0;
          state <= S_LOGIC_WAIT;
        end
        S_LOGIC_WAIT: begin
          if (count >= LC_LAST) begin
            phase  <= PH_DRAW;
            served <= 3'b000;
            count  <= 20'd0;
            state  <= S_SCAN;
          end else begin
            count <= count + 20'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign go       = (state == S_GO) ? grant : 3'b000;
  assign logic_go = (state == S_LOGIC);
  assign busy     = (state != S_IDLE);
  assign erase    = (state != S_IDLE) && (phase == PH_ERASE);

  always_comb begin
    x       = '0;
    y       = '0;
    colour  = BLACK;
    writeEn = 1'b0;
    if (state == S_RUN) begin
      for (int i = 0; i < 3; i++) begin
        if (grant[i]) begin
          x       = x_in[i*COORD_W +: COORD_W];
          y       = y_in[i*COORD_W +: COORD_W];
          colour  = erase ? BLACK : colour_in[i*COLOUR_W +: COLOUR_W];
          writeEn = wen_in[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_draw_arbiter.sv
// Scoreboard bench for draw_arbiter: expected grant order is queued by the
// stimulus, a negedge monitor checks go pulses and the pixel port.
module tb_draw_arbiter;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        frame_tick = 1'b0;
  logic [2:0]  req = 3'b000;
  logic [2:0]  done = 3'b000;
  logic [29:0] x_in = '0;
  logic [29:0] y_in = '0;
  logic [8:0]  colour_in = '0;
  logic [2:0]  wen_in = 3'b000;
  logic [2:0]  go, grant, colour;
  logic [9:0]  x, y;
  logic        writeEn, erase, logic_go, busy, timeout_err, overrun_err;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int tick_cyc = 0;

  logic [2:0] exp_q[$];
  logic [2:0] owner = 3'b000;
  logic       phase_draw = 1'b0;
  int go_cnt = 0, lgo_cnt = 0, busy_cyc = 0, wen_cyc = 0;
  int first_go_cyc = -1, lgo_cyc = -1;
  int done_after[3];
  int dcnt[3];

  draw_arbiter #(.TIMEOUT(20'd20), .LOGIC_CYCLES(20'd12)) dut (
    .clk(clk), .resetn(resetn), .frame_tick(frame_tick), .req(req), .done(done),
    .x_in(x_in), .y_in(y_in), .colour_in(colour_in), .wen_in(wen_in),
    .go(go), .grant(grant), .x(x), .y(y), .colour(colour), .writeEn(writeEn),
    .erase(erase), .logic_go(logic_go), .busy(busy),
    .timeout_err(timeout_err), .overrun_err(overrun_err)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  function automatic logic [2:0] col_of(input logic [2:0] o);
    case (o)
      3'b001:  return colour_in[2:0];
      3'b010:  return colour_in[5:3];
      3'b100:  return colour_in[8:6];
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [9:0] slice10(input logic [29:0] v, input logic [2:0] o);
    case (o)
      3'b001:  return v[9:0];
      3'b010:  return v[19:10];
      3'b100:  return v[29:20];
      default: return 10'd0;
    endcase
  endfunction

  // Requester model: done pulses done_after[i] cycles after its go (0 = never).
  initial forever begin
    @(posedge clk);
    #2;
    for (int i = 0; i < 3; i++) begin
      if (!resetn) begin
        dcnt[i] = 0;
        done[i] = 1'b0;
      end else if (go[i]) begin
        dcnt[i] = done_after[i];
        done[i] = 1'b0;
      end else if (dcnt[i] > 0) begin
        dcnt[i] = dcnt[i] - 1;
        done[i] = (dcnt[i] == 0);
      end else begin
        done[i] = 1'b0;
      end
    end
  end

  // Monitor
  initial forever begin
    @(negedge clk);
    if (resetn) begin
      if (frame_tick && !busy) begin
        phase_draw   = 1'b0;
        first_go_cyc = -1;
        lgo_cyc      = -1;
      end
      if (busy) busy_cyc++;
      if (go != 3'b000) begin
        go_cnt++;
        if (first_go_cyc < 0) first_go_cyc = cyc;
        check("grant_matches_go", grant, go);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_go: got %b required no pulse", go);
        end else begin
          owner = exp_q.pop_front();
          check("go_order", go, owner);
        end
      end
      if (writeEn) begin
        wen_cyc++;
        check("pix_colour", colour, phase_draw ? col_of(owner) : 3'b000);
        check("pix_x", x, slice10(x_in, owner));
        check("pix_y", y, slice10(y_in, owner));
        check("pix_erase", erase, !phase_draw);
      end
      if (logic_go) begin
        lgo_cnt++;
        if (lgo_cyc < 0) lgo_cyc = cyc;
        phase_draw = 1'b1;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic frame();
    frame_tick = 1'b1;
    tick_cyc = cyc;
    step(1);
    frame_tick = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    step(2);
    while (busy && n < 400) begin
      step(1);
      n++;
    end
    check(name, busy, 0);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    step(2);
    resetn = 1'b1;
    step(1);
  endtask

  initial begin
    int g0, l0, w0, b0;
    done_after = '{5, 5, 5};
    dcnt = '{0, 0, 0};
    x_in = {10'd300, 10'd200, 10'd100};
    y_in = {10'd33, 10'd22, 10'd11};

    // Reset state
    step(2);
    check("rst_grant", grant, 0);
    check("rst_busy", busy, 0);
    check("rst_errs", {timeout_err, overrun_err}, 0);
    check("rst_pix", {writeEn, x, y, colour}, 0);
    check("rst_pulses", {go, logic_go, erase}, 0);
    resetn = 1'b1;
    step(2);

    // Full frame, all three requesters
    colour_in = 9'h1FF; wen_in = 3'b111; req = 3'b111;
    exp_q = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    g0 = go_cnt; l0 = lgo_cnt; w0 = wen_cyc;
    frame();
    wait_idle("t1_idle");
    check("t1_go_count", go_cnt - g0, 6);
    check("t1_logic_go", lgo_cnt - l0, 1);
    check("t1_wen_cycles", wen_cyc - w0, 30);
    check("t1_go_latency", first_go_cyc - tick_cyc, 2);
    check("t1_q_empty", exp_q.size(), 0);
    check("t1_errs", {timeout_err, overrun_err}, 0);

    // Brick never finishes: timeout in both phases
    colour_in = 9'b011_010_101; req = 3'b010; done_after = '{5, 0, 5};
    exp_q = '{3'b010, 3'b010};
    g0 = go_cnt; l0 = lgo_cnt; w0 = wen_cyc;
    frame();
    wait_idle("t2_idle");
    check("t2_go_count", go_cnt - g0, 2);
    check("t2_wen_cycles", wen_cyc - w0, 42);
    check("t2_timeout_err", timeout_err, 1);
    check("t2_overrun_err", overrun_err, 0);
    check("t2_logic_go", lgo_cnt - l0, 1);
    check("t2_q_empty", exp_q.size(), 0);

    // Overrun: second tick four cycles into the frame
    do_reset();
    colour_in = 9'h1FF; req = 3'b111; done_after = '{5, 5, 5};
    exp_q = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    g0 = go_cnt;
    frame();
    step(3);
    frame_tick = 1'b1;
    step(1);
    frame_tick = 1'b0;
    wait_idle("t3_idle");
    check("t3_overrun_err", overrun_err, 1);
    check("t3_timeout_err", timeout_err, 0);
    check("t3_go_count", go_cnt - g0, 6);
    check("t3_q_empty", exp_q.size(), 0);

    // Empty request set
    do_reset();
    req = 3'b000;
    g0 = go_cnt; l0 = lgo_cnt; b0 = busy_cyc;
    frame();
    wait_idle("t4_idle");
    check("t4_busy_cycles", busy_cyc - b0, 15);
    check("t4_logic_go", lgo_cnt - l0, 1);
    check("t4_logic_go_cycle", lgo_cyc - tick_cyc, 2);
    check("t4_go_count", go_cnt - g0, 0);

    // Reset in the middle of a brick RUN
    do_reset();
    req = 3'b010; done_after = '{3, 0, 3};
    exp_q = '{3'b010};
    frame();
    step(4);
    check("t5_pre_wen", writeEn, 1);
    resetn = 1'b0;
    #1;
    check("t5_rst_grant", grant, 0);
    check("t5_rst_wen", writeEn, 0);
    check("t5_rst_busy", busy, 0);
    step(2);
    resetn = 1'b1;
    g0 = go_cnt; l0 = lgo_cnt; b0 = busy_cyc;
    step(30);
    check("t5_quiet_go", go_cnt - g0, 0);
    check("t5_quiet_logic_go", lgo_cnt - l0, 0);
    check("t5_quiet_busy", busy_cyc - b0, 0);
    check("t5_q_empty", exp_q.size(), 0);
    req = 3'b001;
    exp_q = '{3'b001, 3'b001};
    frame();
    wait_idle("t5_idle");
    check("t5_go_count", go_cnt - g0, 2);
    check("t5_q_empty2", exp_q.size(), 0);

    // Round-robin pointer carries across frames; mid-frame req change ignored
    do_reset();
    req = 3'b011; done_after = '{5, 5, 5};
    exp_q = '{3'b001, 3'b010, 3'b001, 3'b010};
    g0 = go_cnt;
    frame();
    step(4);
    req = 3'b111;
    wait_idle("t6_idle1");
    check("t6_q_empty1", exp_q.size(), 0);
    exp_q = '{3'b100, 3'b001, 3'b010, 3'b100, 3'b001, 3'b010};
    frame();
    wait_idle("t6_idle2");
    check("t6_q_empty2", exp_q.size(), 0);
    check("t6_go_count", go_cnt - g0, 10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1);
  end

endmodule
